// File: rtl/ram_tp_ecc_scrub.sv
// Two-port (1W/1R) SECDED RAM with registered read, error capture/counters and write-back scrub.
// Read latency 1 cycle; a user write always wins the write port over a pending scrub.
module ram_tp_ecc_scrub #(
    parameter int WIDTH    = 20,
    parameter int DEPTH    = 128,
    parameter int AWIDTH   = $clog2(DEPTH),
    parameter int ECC_EN   = 1,
    parameter int SCRUB_EN = 1,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  WD,
    input  logic [AWIDTH-1:0] WADDR,
    input  logic              WEN,
    input  logic              INJ_SB,
    input  logic              INJ_DB,
    input  logic [AWIDTH-1:0] RADDR,
    input  logic              REN,
    output logic [WIDTH-1:0]  RD,
    output logic              RD_VALID,
    output logic              SB_CORRECT,
    output logic              DB_DETECT,
    output logic [AWIDTH-1:0] ERR_ADDR,
    output logic [CNT_W-1:0]  SB_COUNT,
    output logic [CNT_W-1:0]  DB_COUNT,
    input  logic              CNT_CLR,
    output logic              SCRUB_BUSY
);

    function automatic int calc_r(input int w);
        int r;
        r = 1;
        while ((1 << r) < (w + r + 1)) r++;
        return r;
    endfunction

    localparam int R  = calc_r(WIDTH);
    localparam int N  = WIDTH + R;
    localparam int CW = N + 1;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    // Codeword bit 0 is overall parity; bits 1..N are classic Hamming positions.
    function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] d);
        logic [CW-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int i = 1; i <= N; i++)
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        for (int p = 0; p < R; p++)
            for (int i = 1; i <= N; i++)
                if ((((i >> p) & 1) == 1) && (i != (1 << p))) c[1 << p] = c[1 << p] ^ c[i];
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    // Returns {db, sb, corrected_data}.
    function automatic logic [WIDTH+1:0] decode(input logic [CW-1:0] c);
        logic [CW-1:0]    f;
        logic [R-1:0]     syn;
        logic [WIDTH-1:0] d;
        logic             sb;
        logic             db;
        int               k;
        syn = '0;
        for (int p = 0; p < R; p++)
            for (int i = 1; i <= N; i++)
                if (((i >> p) & 1) == 1) syn[p] = syn[p] ^ c[i];
        f  = c;
        sb = 1'b0;
        db = 1'b0;
        if (^c) begin
            if (int'(syn) <= N) begin
                f[syn] = ~f[syn];
                sb     = 1'b1;
            end else begin
                db = 1'b1;
            end
        end else if (syn != '0) begin
            db = 1'b1;
        end
        d = '0;
        k = 0;
        for (int i = 1; i <= N; i++)
            if ((i & (i - 1)) != 0) begin
                d[k] = f[i];
                k++;
            end
        return {db, sb, d};
    endfunction

    logic [CW-1:0]     mem_q [DEPTH];
    logic [CW-1:0]     inj_mask;
    logic [CW-1:0]     wr_cw;
    logic [CW-1:0]     rd_cw;
    logic [WIDTH+1:0]  dec;
    logic              user_wr;
    logic              scrub_wr;
    logic              sb_ev;
    logic              db_ev;

    logic [0:0]        state_q, state_d;
    logic [AWIDTH-1:0] scrub_addr_q, scrub_addr_d;
    logic [WIDTH-1:0]  scrub_dat_q, scrub_dat_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic              rd_vld_q;
    logic              sb_q, db_q;
    logic [AWIDTH-1:0] err_addr_q, err_addr_d;
    logic [CNT_W-1:0]  sb_cnt_q, sb_cnt_d;
    logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;

    always_comb begin
        inj_mask = '0;
        if (ECC_EN != 0) begin
            if (INJ_DB)      inj_mask[1:0] = 2'b11;
            else if (INJ_SB) inj_mask[0]   = 1'b1;
        end
    end

    assign wr_cw    = encode(WD) ^ inj_mask;
    assign user_wr  = WEN && ({1'b0, WADDR} < DEPTH_L);
    assign scrub_wr = (state_q == PEND) && !WEN && !RST;

    assign rd_cw = ({1'b0, RADDR} < DEPTH_L) ? mem_q[RADDR] : '0;
    assign dec   = decode(rd_cw);
    assign sb_ev = REN && (ECC_EN != 0) && dec[WIDTH];
    assign db_ev = REN && (ECC_EN != 0) && dec[WIDTH+1];

    always_ff @(posedge CLK) begin
        if (user_wr)       mem_q[WADDR]        <= wr_cw;
        else if (scrub_wr) mem_q[scrub_addr_q] <= encode(scrub_dat_q);
    end

    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        scrub_dat_d  = scrub_dat_q;
        case (state_q)
            IDLE: begin
                // A same-edge user write to the failing address already supersedes the old word.
                if ((SCRUB_EN != 0) && sb_ev && !(WEN && (WADDR == RADDR))) begin
                    state_d      = PEND;
                    scrub_addr_d = RADDR;
                    scrub_dat_d  = dec[WIDTH-1:0];
                end
            end
            default: begin
                if (!WEN || (WADDR == scrub_addr_q)) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_d       = REN ? dec[WIDTH-1:0] : rd_q;
        err_addr_d = (sb_ev || db_ev) ? RADDR : err_addr_q;
        sb_cnt_d   = sb_cnt_q;
        db_cnt_d   = db_cnt_q;
        if (CNT_CLR) begin
            sb_cnt_d = '0;
            db_cnt_d = '0;
        end else begin
            if (sb_ev && (sb_cnt_q != '1)) sb_cnt_d = sb_cnt_q + CNT_W'(1);
            if (db_ev && (db_cnt_q != '1)) db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            scrub_addr_q <= '0;
            scrub_dat_q  <= '0;
            rd_q         <= '0;
            rd_vld_q     <= 1'b0;
            sb_q         <= 1'b0;
            db_q         <= 1'b0;
            err_addr_q   <= '0;
            sb_cnt_q     <= '0;
            db_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            scrub_addr_q <= scrub_addr_d;
            scrub_dat_q  <= scrub_dat_d;
            rd_q         <= rd_d;
            rd_vld_q     <= REN;
            sb_q         <= sb_ev;
            db_q         <= db_ev;
            err_addr_q   <= err_addr_d;
            sb_cnt_q     <= sb_cnt_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    assign RD         = rd_q;
    assign RD_VALID   = rd_vld_q;
    assign SB_CORRECT = sb_q;
    assign DB_DETECT  = db_q;
    assign ERR_ADDR   = err_addr_q;
    assign SB_COUNT   = sb_cnt_q;
    assign DB_COUNT   = db_cnt_q;
    assign SCRUB_BUSY = (state_q == PEND);

endmodule

// File: tb/tb_ram_tp_ecc_scrub.sv
// Directed bench for ram_tp_ecc_scrub: default instance plus a CNT_W=2 instance on shared inputs.
module tb_ram_tp_ecc_scrub;
    localparam int W  = 20;
    localparam int AW = 7;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  WD = '0;
    logic [AW-1:0] WADDR = '0;
    logic          WEN = 1'b0;
    logic          INJ_SB = 1'b0;
    logic          INJ_DB = 1'b0;
    logic [AW-1:0] RADDR = '0;
    logic          REN = 1'b0;
    logic          CNT_CLR = 1'b0;

    logic [W-1:0]  RD;
    logic          RD_VALID, SB_CORRECT, DB_DETECT, SCRUB_BUSY;
    logic [AW-1:0] ERR_ADDR;
    logic [15:0]   SB_COUNT, DB_COUNT;

    logic [W-1:0]  c_RD;
    logic          c_RD_VALID, c_SB_CORRECT, c_DB_DETECT, c_SCRUB_BUSY;
    logic [AW-1:0] c_ERR_ADDR;
    logic [1:0]    c_SB_COUNT, c_DB_COUNT;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    ram_tp_ecc_scrub dut (
        .CLK(CLK), .RST(RST), .WD(WD), .WADDR(WADDR), .WEN(WEN), .INJ_SB(INJ_SB),
        .INJ_DB(INJ_DB), .RADDR(RADDR), .REN(REN), .RD(RD), .RD_VALID(RD_VALID),
        .SB_CORRECT(SB_CORRECT), .DB_DETECT(DB_DETECT), .ERR_ADDR(ERR_ADDR),
        .SB_COUNT(SB_COUNT), .DB_COUNT(DB_COUNT), .CNT_CLR(CNT_CLR), .SCRUB_BUSY(SCRUB_BUSY)
    );

    ram_tp_ecc_scrub #(.CNT_W(2)) dut_c (
        .CLK(CLK), .RST(RST), .WD(WD), .WADDR(WADDR), .WEN(WEN), .INJ_SB(INJ_SB),
        .INJ_DB(INJ_DB), .RADDR(RADDR), .REN(REN), .RD(c_RD), .RD_VALID(c_RD_VALID),
        .SB_CORRECT(c_SB_CORRECT), .DB_DETECT(c_DB_DETECT), .ERR_ADDR(c_ERR_ADDR),
        .SB_COUNT(c_SB_COUNT), .DB_COUNT(c_DB_COUNT), .CNT_CLR(CNT_CLR), .SCRUB_BUSY(c_SCRUB_BUSY)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic sb, input logic db);
        WEN = 1'b1; WADDR = a; WD = d; INJ_SB = sb; INJ_DB = db;
        cyc();
        WEN = 1'b0; INJ_SB = 1'b0; INJ_DB = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        REN = 1'b1; RADDR = a;
        cyc();
        REN = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc();
        cyc();
        checks++; if (RD !== 20'h0) begin errors++; $display("FAIL rst_rd got %h exp 0", RD); end
        checks++; if ({RD_VALID, SB_CORRECT, DB_DETECT, SCRUB_BUSY} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {RD_VALID, SB_CORRECT, DB_DETECT, SCRUB_BUSY}); end
        checks++; if (ERR_ADDR !== 7'd0) begin errors++; $display("FAIL rst_erraddr got %0d exp 0", ERR_ADDR); end
        checks++; if ({SB_COUNT, DB_COUNT} !== 32'h0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", SB_COUNT, DB_COUNT); end
        RST = 1'b0;
    endtask

    task automatic test_basic();
        wr(7'd5, 20'hABCDE, 1'b0, 1'b0);
        rd(7'd5);
        checks++; if (RD !== 20'hABCDE) begin errors++; $display("FAIL basic_rd got %h exp abcde", RD); end
        checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL basic_vld got %b exp 1", RD_VALID); end
        checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {SB_CORRECT, DB_DETECT}); end
        cyc();
        checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL basic_vld_drop got %b exp 0", RD_VALID); end
        checks++; if (RD !== 20'hABCDE) begin errors++; $display("FAIL basic_rd_hold got %h exp abcde", RD); end
    endtask

    task automatic test_sb_scrub();
        wr(7'd9, 20'h12345, 1'b1, 1'b0);
        rd(7'd9);
        checks++; if (RD !== 20'h12345) begin errors++; $display("FAIL sb_rd got %h exp 12345", RD); end
        checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b10) begin errors++; $display("FAIL sb_flags got %b exp 10", {SB_CORRECT, DB_DETECT}); end
        checks++; if (ERR_ADDR !== 7'd9) begin errors++; $display("FAIL sb_erraddr got %0d exp 9", ERR_ADDR); end
        checks++; if (SB_COUNT !== 16'd1) begin errors++; $display("FAIL sb_count got %0d exp 1", SB_COUNT); end
        checks++; if (SCRUB_BUSY !== 1'b1) begin errors++; $display("FAIL sb_busy got %b exp 1", SCRUB_BUSY); end
        cyc();
        checks++; if (SCRUB_BUSY !== 1'b0) begin errors++; $display("FAIL sb_busy_end got %b exp 0", SCRUB_BUSY); end
        rd(7'd9);
        checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b00) begin errors++; $display("FAIL sb_reread_flags got %b exp 00", {SB_CORRECT, DB_DETECT}); end
        checks++; if (RD !== 20'h12345) begin errors++; $display("FAIL sb_reread_rd got %h exp 12345", RD); end
    endtask

    task automatic test_db();
        wr(7'd3, 20'h0F0F0, 1'b0, 1'b1);
        rd(7'd3);
        checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b01) begin errors++; $display("FAIL db_flags got %b exp 01", {SB_CORRECT, DB_DETECT}); end
        checks++; if (DB_COUNT !== 16'd1) begin errors++; $display("FAIL db_count got %0d exp 1", DB_COUNT); end
        checks++; if (SCRUB_BUSY !== 1'b0) begin errors++; $display("FAIL db_busy got %b exp 0", SCRUB_BUSY); end
        checks++; if (ERR_ADDR !== 7'd3) begin errors++; $display("FAIL db_erraddr got %0d exp 3", ERR_ADDR); end
        rd(7'd3);
        checks++; if (DB_DETECT !== 1'b1) begin errors++; $display("FAIL db_reread got %b exp 1", DB_DETECT); end
        checks++; if (DB_COUNT !== 16'd2) begin errors++; $display("FAIL db_count2 got %0d exp 2", DB_COUNT); end
    endtask

    task automatic test_cancel();
        wr(7'd7, 20'h55555, 1'b1, 1'b0);
        rd(7'd7);
        checks++; if ({SB_CORRECT, SCRUB_BUSY} !== 2'b11) begin errors++; $display("FAIL cancel_sb got %b exp 11", {SB_CORRECT, SCRUB_BUSY}); end
        checks++; if (RD !== 20'h55555) begin errors++; $display("FAIL cancel_rd got %h exp 55555", RD); end
        wr(7'd7, 20'h00001, 1'b0, 1'b0);
        checks++; if (SCRUB_BUSY !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b exp 0", SCRUB_BUSY); end
        rd(7'd7);
        checks++; if (RD !== 20'h00001) begin errors++; $display("FAIL cancel_rd2 got %h exp 00001", RD); end
        checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b00) begin errors++; $display("FAIL cancel_flags got %b exp 00", {SB_CORRECT, DB_DETECT}); end
    endtask

    task automatic test_saturate();
        CNT_CLR = 1'b1;
        cyc();
        CNT_CLR = 1'b0;
        checks++; if ({SB_COUNT, DB_COUNT} !== 32'h0) begin errors++; $display("FAIL clr_counts got %0d/%0d exp 0/0", SB_COUNT, DB_COUNT); end
        for (int i = 0; i < 4; i++) begin
            wr(7'd10, 20'h0AAAA, 1'b1, 1'b0);
            rd(7'd10);
        end
        checks++; if (c_SB_COUNT !== 2'd3) begin errors++; $display("FAIL sat_count got %0d exp 3", c_SB_COUNT); end
        checks++; if (SB_COUNT !== 16'd4) begin errors++; $display("FAIL wide_count got %0d exp 4", SB_COUNT); end
        wr(7'd10, 20'h0AAAA, 1'b1, 1'b0);
        REN = 1'b1; RADDR = 7'd10; CNT_CLR = 1'b1;
        cyc();
        REN = 1'b0; CNT_CLR = 1'b0;
        checks++; if (SB_CORRECT !== 1'b1) begin errors++; $display("FAIL clrsb_flag got %b exp 1", SB_CORRECT); end
        checks++; if (SB_COUNT !== 16'd0) begin errors++; $display("FAIL clrsb_count got %0d exp 0", SB_COUNT); end
        checks++; if (c_SB_COUNT !== 2'd0) begin errors++; $display("FAIL clrsb_ccount got %0d exp 0", c_SB_COUNT); end
    endtask

    task automatic test_back_to_back();
        wr(7'd2, 20'h22222, 1'b0, 1'b0);
        WEN = 1'b1; WADDR = 7'd2; WD = 20'h11111; REN = 1'b1; RADDR = 7'd2;
        cyc();
        WEN = 1'b0; REN = 1'b0;
        checks++; if (RD !== 20'h22222) begin errors++; $display("FAIL rfirst_rd got %h exp 22222", RD); end
        rd(7'd2);
        checks++; if (RD !== 20'h11111) begin errors++; $display("FAIL rfirst_new got %h exp 11111", RD); end
    endtask

    task automatic test_reset_pend();
        wr(7'd12, 20'h5A5A5, 1'b1, 1'b0);
        rd(7'd12);
        checks++; if (SCRUB_BUSY !== 1'b1) begin errors++; $display("FAIL rpend_busy got %b exp 1", SCRUB_BUSY); end
        RST = 1'b1;
        cyc();
        checks++; if ({RD_VALID, SB_CORRECT, DB_DETECT, SCRUB_BUSY} !== 4'b0) begin errors++; $display("FAIL rpend_flags got %b exp 0000", {RD_VALID, SB_CORRECT, DB_DETECT, SCRUB_BUSY}); end
        checks++; if ({RD, ERR_ADDR, SB_COUNT, DB_COUNT} !== '0) begin errors++; $display("FAIL rpend_regs got %h/%0d/%0d/%0d exp 0", RD, ERR_ADDR, SB_COUNT, DB_COUNT); end
        RST = 1'b0;
        cyc();
        rd(7'd12);
        checks++; if (SB_CORRECT !== 1'b1) begin errors++; $display("FAIL rpend_noscrub got %b exp 1", SB_CORRECT); end
        checks++; if (RD !== 20'h5A5A5) begin errors++; $display("FAIL rpend_rd got %h exp 5a5a5", RD); end
        checks++; if (SB_COUNT !== 16'd1) begin errors++; $display("FAIL rpend_count got %0d exp 1", SB_COUNT); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sb_scrub();
        test_db();
        test_cancel();
        test_saturate();
        test_back_to_back();
        test_reset_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
